// File: rtl/wishbone_bus_scheduler.sv
// Registered two-requester WB4 scheduler: data port has priority, fetch is protected by a starvation limit.
// Define WB_SCHED_TIMEOUT_EN to add a stalled-slave watchdog that force-completes the owner's access.
module wishbone_bus_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  // memory-side master
  output logic [ADDR_W-1:0] master_adr_o,
  output logic [DATA_W-1:0] master_dat_o,
  input  logic [DATA_W-1:0] master_dat_i,
  output logic              master_we_o,
  output logic              master_cyc_o,
  output logic              master_stb_o,
  input  logic              master_ack_i,
  // instruction-fetch requester
  input  logic [ADDR_W-1:0] inst_adr_i,
  input  logic [DATA_W-1:0] inst_dat_i,
  output logic [DATA_W-1:0] inst_dat_o,
  input  logic              inst_we_i,
  input  logic              inst_cyc_i,
  input  logic              inst_stb_i,
  output logic              inst_ack_o,
  // load/store requester
  input  logic [ADDR_W-1:0] data_adr_i,
  input  logic [DATA_W-1:0] data_dat_i,
  output logic [DATA_W-1:0] data_dat_o,
  input  logic              data_we_i,
  input  logic              data_cyc_i,
  input  logic              data_stb_i,
  output logic              data_ack_o,
  output logic [1:0]        owner_o,
  output logic              timeout_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GNT_INST = 2'b01,
    GNT_DATA = 2'b10
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   starve_q;
  logic            req_inst;
  logic            req_data;
  logic            fire;
  logic [DATA_W-1:0] rd_dat;

  assign req_inst = inst_cyc_i & inst_stb_i;
  assign req_data = data_cyc_i & data_stb_i;
  assign owner_o  = state_q;

  always_comb begin
    master_adr_o = '0;
    master_dat_o = '0;
    master_we_o  = 1'b0;
    master_cyc_o = 1'b0;
    master_stb_o = 1'b0;
    unique case (state_q)
      GNT_INST: begin
        master_adr_o = inst_adr_i;
        master_dat_o = inst_dat_i;
        master_we_o  = inst_we_i;
        master_cyc_o = inst_cyc_i;
        master_stb_o = inst_stb_i;
      end
      GNT_DATA: begin
        master_adr_o = data_adr_i;
        master_dat_o = data_dat_i;
        master_we_o  = data_we_i;
        master_cyc_o = data_cyc_i;
        master_stb_o = data_stb_i;
      end
      default: ;
    endcase
    if (fire) begin
      master_cyc_o = 1'b0;
      master_stb_o = 1'b0;
    end
  end

  assign rd_dat     = fire ? TIMEOUT_DATA : master_dat_i;
  assign inst_dat_o = rd_dat;
  assign data_dat_o = rd_dat;
  assign inst_ack_o = (state_q == GNT_INST) & (master_ack_i | fire);
  assign data_ack_o = (state_q == GNT_DATA) & (master_ack_i | fire);
  assign timeout_o  = fire;

  // A watchdog fire forces master CYC low, so the release test below also covers it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_data && !(req_inst && starve_q == STARVE_MAX)) begin
            state_q <= GNT_DATA;
            if (req_inst && starve_q < STARVE_MAX) starve_q <= starve_q + 1'b1;
          end else if (req_inst) begin
            state_q  <= GNT_INST;
            starve_q <= '0;
          end
        end
        default: if (!master_cyc_o) state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wdog_q;
  logic [CNT_W-1:0] wdog_d;

  assign fire = (state_q != IDLE) && (wdog_q == CNT_MAX);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == IDLE || fire || master_ack_i) wdog_d = '0;
    else if (master_stb_o)                       wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end
`else
  assign fire = 1'b0;
`endif

endmodule

// File: doc/wishbone_bus_scheduler.md
Name: wishbone_bus_scheduler

Overview:
Registered two-requester Wishbone scheduler that shares the single memory-side WB4 bus between the core's instruction-fetch and data ports.
- Grant is latched for the whole owner cycle (CYC held), so a multi-beat or locked access is never split.
- Data port has priority, bounded by a starvation limit so fetch always progresses.
- Sits between the core's two WB4 masters and the memory/peripheral interconnect.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants issued while an inst request is pending; the next grant goes to inst.
TIMEOUT, 255, cycles an owner may wait with STB high and no ACK before the watchdog fires (optional feature only).
CNT_W, $clog2(TIMEOUT+1), width of the watchdog counter (derived, do not override).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-low.
master_wb  WB4.master  bundle  downstream bus: ADR, DAT_O, DAT_I, WE, CYC, STB, ACK.
inst_wb  WB4.slave  bundle  instruction-fetch requester.
data_wb  WB4.slave  bundle  load/store requester.
owner_o  out  2  current grant: 2'b00 idle, 2'b01 inst, 2'b10 data.
timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Request definition: req_x = x_wb.CYC & x_wb.STB.
- FSM states: IDLE, GNT_INST, GNT_DATA. Registered state; async reset to IDLE.
- Reset values: owner_o=00, timeout_o=0, starve counter=0, watchdog=0. In IDLE, master CYC/STB/WE=0, ADR/DAT_O=0 and both requester ACKs=0.
- IDLE -> GNT_DATA when req_data and not (req_inst and starve==STARVE_LIMIT).
- IDLE -> GNT_INST when req_inst and (not req_data or starve==STARVE_LIMIT).
- Otherwise stay in IDLE.
- GNT_x -> IDLE on the cycle after the owner's CYC is sampled low. There is always exactly one IDLE cycle between grants, so no back-to-back handover.
- Latency: a request first present in cycle N with state IDLE gives owner_o and master CYC/STB in cycle N+1.
- Mux: master ADR/DAT_O/WE/CYC/STB come combinationally from the owner per owner_o. Master DAT_I is broadcast to both requesters.
- ACK routing: only the owner receives master ACK; the non-owner's ACK is 0 at all times.
- The owner may drop STB between beats while keeping CYC; the grant is held and the owner re-issues STB with zero penalty.
- Starve counter, evaluated at each grant decision:
  - data grant with req_inst high: counter +1, saturating at STARVE_LIMIT;
  - inst grant: counter cleared to 0;
  - data grant with req_inst low: counter unchanged.
- Simultaneous events:
  - Owner releases CYC while the other side requests: go to IDLE, and grant the other side in the following cycle per the rules above.
  - ACK and CYC drop in the same cycle is legal; the ACK reaches the owner.
- Reset mid-transfer: all state clears immediately (async) and master CYC drops. Requesters must restart the transfer.

Optional Feature:
Macro WB_SCHED_TIMEOUT_EN.
Defined:
- The watchdog counts owner cycles with master STB=1 and ACK=0; it clears on ACK or in IDLE.
- On reaching TIMEOUT:
  - timeout_o pulses 1 cycle;
  - the owner receives a forced ACK with DAT_I=32'hDEAD_BEEF;
  - master CYC/STB are forced 0 that cycle;
  - state goes to IDLE.
Undefined:
- No watchdog logic is present; timeout_o is tied 0.
- A stalled slave hangs the owner indefinitely.

Test Plan:
- Inst-only fetch to ADR 0x100; slave ACKs 1 cycle after STB -> owner_o=01 one cycle after request; inst ACK=1 with DAT_I=0x00000013; data ACK stays 0; IDLE cycle follows CYC drop.
- Inst and data request in the same IDLE cycle -> owner_o=10; master ADR=data ADR; inst granted only after data drops CYC plus 1 IDLE cycle.
- Data requests continuously with inst pending, STARVE_LIMIT=4 -> 4 data grants, then the 5th grant goes to inst; starve counter returns to 0.
- Data holds CYC for 3 beats with STB low for 1 cycle between beats while inst requests -> grant never switches mid-cycle; all 3 ACKs go to data.
- Assert rst low during a data beat with STB=1 -> in the same cycle master CYC=0, owner_o=00 and timeout_o=0; after release, a new request is granted normally.
- With WB_SCHED_TIMEOUT_EN and TIMEOUT=8, slave never ACKs -> timeout_o pulses 8 cycles after STB rises; owner ACK=1 with DAT_I=0xDEADBEEF; state IDLE the next cycle.
